// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full adder walks the operands
// LSB first, then presents a registered result with carry-out and overflow.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] sa_q,     sa_d;
  logic [WIDTH-1:0] sb_q,     sb_d;
  logic [WIDTH-1:0] sr_q,     sr_d;
  logic             c_q,      c_d;
  logic             cm_q,     cm_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;

  logic fa_sum;
  logic fa_cout;
  logic sr_lsb_unused;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // The bit in sr[0] has already been folded into the result by the time it would shift out.
  assign sr_lsb_unused = sr_q[0];

  // Next-state and datapath update for the serial add sequence.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    c_d      = c_q;
    cm_d     = cm_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          c_d     = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        sr_d  = {fa_sum, sr_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        c_d   = fa_cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // c_q here is the carry into the MSB; overflow is derived from it.
          cm_d     = c_q;
          result_d = {fa_sum, sr_q[WIDTH-1:1]};
          cout_d   = fa_cout;
          state_d  = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      c_q      <= 1'b0;
      cm_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      c_q      <= c_d;
      cm_q     <= cm_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  // Both terms are flops loaded on the same completing edge.
  assign overflow = cm_q ^ cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed and random operations
// compared against an integer-arithmetic reference model.

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] prev_exp = '0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Returns {overflow, cout, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                         input logic osub, input logic ocin);
    int ua, ub, sa, sb, r, s;
    logic [W-1:0] res;
    logic co, ov;
    ua = int'(oa);
    ub = int'(ob);
    sa = int'($signed(oa));
    sb = int'($signed(ob));
    if (osub) begin
      r  = ua - ub;
      co = (ua >= ub);
      s  = sa - sb;
    end else begin
      r  = ua + ub + int'(ocin);
      co = (r > 255);
      s  = sa + sb + int'(ocin);
    end
    ov  = (s > 127) || (s < -128);
    res = r[W-1:0];
    return {ov, co, res};
  endfunction

  // Issue one operation and check timing, hold behaviour and final values.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic osub,
                       input logic ocin, input bit hold, input string tag);
    logic [W+1:0] e;
    int n, nbusy;
    bit seen, held_bad, both_bad;
    e = model(oa, ob, osub, ocin);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle_before_start: busy=%b done=%b expected 0 0", tag, busy, done);
    end
    start = 1'b1; a = oa; b = ob; sub = osub; cin = ocin;
    @(posedge clk);
    n = 0; nbusy = 0; seen = 0; held_bad = 0; both_bad = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (!hold) start = 1'b0;
      a = W'($urandom); b = W'($urandom);
      sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      if (busy === 1'b1 && done === 1'b1) both_bad = 1;
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        if (busy === 1'b1) nbusy++;
        if (result !== prev_exp) held_bad = 1;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, n);
    end
    n_cmp++;
    if (n != W + 1) begin
      n_err++;
      $display("FAIL %s latency: done seen %0d edges after sampling, expected %0d", tag, n, W + 1);
    end
    n_cmp++;
    if (nbusy != W) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", tag, nbusy, W);
    end
    n_cmp++;
    if (held_bad || both_bad) begin
      n_err++;
      $display("FAIL %s hold_or_overlap: result_moved=%0d busy_and_done=%0d expected 0 0",
               tag, held_bad, both_bad);
    end
    n_cmp++;
    if (result !== e[W-1:0] || cout !== e[W] || overflow !== e[W+1]) begin
      n_err++;
      $display("FAIL %s value: result=%h cout=%b ovf=%b expected %h %b %b",
               tag, result, cout, overflow, e[W-1:0], e[W], e[W+1]);
    end
    prev_exp = e[W-1:0];
  endtask

  task automatic test_reset();
    bit bad;
    #2 rst_n = 1'b0;
    #2;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
               busy, done, result, cout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL reset_quiet: busy/done went high with start=0, expected 0");
    end
    prev_exp = '0;
  endtask

  task automatic test_directed();
    do_op(8'h5A, 8'h23, 1'b0, 1'b0, 1'b0, "add_5A_23");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, "add_FF_01");
    do_op(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, "add_7F_00_c");
    do_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b0, "sub_10_20");
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, "sub_80_01");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || cout !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
               busy, done, result, cout, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev_exp = '0;
  endtask

  task automatic test_back_to_back();
    do_op(8'h33, 8'h44, 1'b0, 1'b0, 1'b1, "b2b_first_held");
    do_op(8'hC8, 8'h3C, 1'b1, 1'b0, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_mid_run();
    bit bad;
    @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55; sub = 1'b0; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      n_err++;
      $display("FAIL mid_run_reset: busy=%b done=%b result=%h expected 0 0 00", busy, done, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL mid_run_no_done: activity or nonzero result after aborted op, expected none");
    end
    prev_exp = '0;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_async_reset();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    @(negedge clk);
    start = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract sequencer for the ALU. It shares one 1-bit FULL_ADDER cell across the WIDTH bits of an operand, feeding it one bit per clock from LSB to MSB. It keeps the carry in a flop between bits and assembles the WIDTH-bit result. It accepts a start request from the ALU decode stage and returns a registered result with a `done` pulse, carry-out and signed overflow flags.

## Interface
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request new operation; sampled only in IDLE.
- `sub`  in  1: 0 = A + B + cin, 1 = A − B (two's complement); sampled with `start`.
- `a`  in  WIDTH: operand A; sampled with `start`.
- `b`  in  WIDTH: operand B; sampled with `start`.
- `cin`  in  1: carry-in for add; ignored when `sub`=1.
- `busy`  out  1: high while bits are being processed (state RUN).
- `done`  out  1: one-cycle pulse; result and flags are valid from this cycle on.
- `result`  out  WIDTH: last completed sum/difference; held until the next completion.
- `cout`  out  1: final carry out of the MSB. For subtract, 1 = no borrow.
- `overflow`  out  1: signed overflow, carry into MSB XOR carry out of MSB.

## Operation
- Internal: shift registers `sa` and `sb` (WIDTH each), `sr` (WIDTH), carry flop `c`, MSB carry-in flop `cm`, bit counter `cnt` (clog2(WIDTH) bits), and the 3-state FSM IDLE / RUN / DONE.
- One FULL_ADDER instance has inputs `a`=`sa[0]`, `b`=`sb[0]`, `cin`=`c`.
- IDLE:
  - If `start`=1: `sa`←`a`, `sb`←(`sub` ? ~`b` : `b`), `c`←(`sub` ? 1 : `cin`), `cnt`←0, go to RUN.
  - If `start`=0: stay in IDLE.
- RUN, every edge:
  - `sr`←{adder sum, `sr[WIDTH-1:1]`}.
  - `sa` and `sb` shift right by 1.
  - `c`←adder cout.
  - `cnt`←`cnt`+1.
  - When `cnt`=WIDTH-1, `cm`←`c` (the carry entering the MSB).
  - On the edge where `cnt`=WIDTH-1: load `result`←{sum, `sr[WIDTH-1:1]`}, `cout`←adder cout, `overflow`←`c` XOR adder cout, go to DONE.
- DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `start` is ignored in RUN and DONE. It is not queued.
- Arithmetic is modulo 2^WIDTH. `result`, `cout` and `overflow` match a WIDTH-bit parallel adder with the same inputs.
- `a`, `b`, `sub` and `cin` may change freely after the sampling edge.

## Timing
- Reset (async, `rst_n`=0):
  - State → IDLE.
  - `busy`=0, `done`=0, `result`=0, `cout`=0, `overflow`=0.
  - All internal registers cleared.
  - Takes effect immediately, with no clock needed.
- Reset mid-RUN or mid-DONE aborts the operation. No `done` is produced and `result` reads 0.
- Sampling edge E0 (IDLE with `start`=1) is followed by RUN for edges E1..E_WIDTH. `busy` is high from after E0 until after E_WIDTH.
- `done` is high in the cycle after E_WIDTH. `result`, `cout` and `overflow` change only at E_WIDTH.
- Latency: `done` is seen WIDTH+1 edges after the sampling edge.
- Back-to-back: the earliest next start is sampled at the edge ending the DONE cycle + 1, giving one operation per WIDTH+2 cycles.
- `busy` and `done` are never high in the same cycle.
- `busy`, `done` and all flags are registered or decoded from state only. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `rst_n`=0 mid-simulation → all outputs 0 immediately. Release, then hold `start`=0 for 20 cycles → `busy`=`done`=0.
- Add, WIDTH=8: `a`=8'h5A, `b`=8'h23, `cin`=0 → `done` exactly 9 edges after the sampling edge. `result`=8'h7D, `cout`=0, `overflow`=0. `busy` high for exactly 8 cycles.
- Add, carry and overflow cases:
  - 8'hFF+8'h01, `cin`=0 → 8'h00, `cout`=1, `overflow`=0.
  - 8'h7F+8'h00, `cin`=1 → 8'h80, `cout`=0, `overflow`=1.
- Subtract:
  - `sub`=1, 8'h10−8'h20 → 8'hF0, `cout`=0, `overflow`=0.
  - 8'h80−8'h01 → 8'h7F, `cout`=1, `overflow`=1.
- Start ignored and back-to-back:
  - Hold `start`=1 continuously with different operands changed during RUN → only the first operation is sampled.
  - The next operation is sampled in the IDLE cycle after `done`. `result` holds its old value until the second `done`.
- Reset mid-RUN: pulse `rst_n` low at bit 4 of 8'hAA+8'h55 → `busy` drops immediately, no `done`, `result`=0. A following 8'h01+8'h01 gives 8'h02.
